dump_serializer: RTL and testbench
==================================

# dump_serializer

Turns a snapshot buffer into the byte stream returned to the host over UART. On a one-cycle `start_dump` request (the synchronized dump-opcode pulse), it reads `entry_count` words from a synchronous-read log memory and emits each word big-endian, one byte at a time, on an AXI-Stream byte master. The stream ends with a 4-byte sentinel whose last byte carries `tlast`. The block sits directly upstream of the UART TX handshake stage and consumes the dump request produced by the UART command detector.

## Interface
- `WORD_WIDTH`, 64: log word width; must be a multiple of 8, range 8..128.
- `ADDR_WIDTH`, 8: log address width; depth is 2^ADDR_WIDTH entries.
- `clk` input 1: single clock; all logic is in this domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start_dump` input 1: one-cycle dump request.
- `entry_count` input ADDR_WIDTH+1: number of words to dump; sampled only when a start is accepted.
- `rd_en` output 1: memory read strobe.
- `rd_addr` output ADDR_WIDTH: memory read address.
- `rd_data` input WORD_WIDTH: memory data, valid exactly 1 cycle after `rd_en`.
- `m_axis_tdata` output 8: stream byte.
- `m_axis_tvalid` output 1: stream byte valid.
- `m_axis_tready` input 1: downstream ready.
- `m_axis_tlast` output 1: marks the final sentinel byte.
- `busy` output 1: high from the accepted start until the `tlast` handshake.

## Operation
- **States:** IDLE, HDR, RD, WAIT, SHIFT, SENT.
- **IDLE**
  - `start_dump`=1 latches `count` = min(`entry_count`, 2^ADDR_WIDTH).
  - Clears word index `idx`.
  - Next state: HDR if the header is enabled; else RD if `count`>0; else SENT.
- **RD:** `rd_en`=1 with `rd_addr`=`idx` for exactly one cycle, then WAIT.
- **WAIT:** loads `rd_data` into the shift register, sets `m_axis_tvalid`, clears the byte counter, then SHIFT.
- **SHIFT**
  - `m_axis_tdata` = shift[WORD_WIDTH-1 -: 8].
  - On each handshake (tvalid & tready): shift left by 8 and increment the byte counter.
  - On the handshake of byte WORD_WIDTH/8-1: `idx`++. Go to SENT if `idx`+1==`count`, else RD.
- **SENT:** emits 0xDE, 0xAD, 0xBE, 0xEF with `tlast`=1 on 0xEF only. On the 0xEF handshake: IDLE, `busy`=0.
- `start_dump` while `busy` is ignored and not queued.
- `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` are registered. Once tvalid is high, all three hold stable until the handshake; tvalid never drops without one.
- `idx` counts 0..`count`-1 and never wraps. `count`==2^ADDR_WIDTH reads every address exactly once.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `m_axis_tdata`=0x00, `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0. The state goes to IDLE immediately, asynchronously.
- Reset asserted mid-dump: the stream is abandoned with no further bytes and no `tlast`. After `rst_n` deasserts, the block waits for a new start.
- Start latency (header disabled, `count`>0):
  - Start sampled at edge E0.
  - `rd_en` is high during the cycle after E0.
  - `m_axis_tvalid` rises after E2.
- Header enabled: the header adds exactly its byte count plus zero bubble cycles before RD.
- Word boundary: after the last-byte handshake at edge Ek, the next word's first byte is valid after Ek+2, a fixed 2-cycle bubble.
- Within a word, with `tready` held at 1, one byte is transferred per cycle.
- The transition from the last word to SENT has no bubble: 0xDE is valid the cycle after the final data handshake.

## Configuration
- `DUMP_HEADER_EN` defined: three bytes are emitted before the data: 0xA5, then `count` zero-extended to 16 bits, MSB byte first. The HDR state is present.
- `DUMP_HEADER_EN` undefined: no header and no HDR state. The stream is data bytes followed by the sentinel.

## Structure
- Package `dump_pkg` holds:
  - state enumeration;
  - sentinel bytes constant (0xDEADBEEF);
  - header magic 0xA5;
  - `SENTINEL_BYTES`=4.
- Sub-module `byte_serializer` holds the word shift register, byte counter and registered AXIS valid/data hold logic. It is loaded from WAIT and reports a last-byte-accepted pulse.

## Test plan
- Two-word dump with `tready`=1:
  - Memory[0]=0x0102030405060708, memory[1]=0x1112131415161718, `entry_count`=2.
  - Expect bytes 01..08, 11..18, DE AD BE EF.
  - `tlast` only on EF; `rd_addr` sequence 0, 1; one 2-cycle bubble between the words.
- Backpressure: `tready` follows the pattern 1,0,0,1 repeating. Expect the same byte sequence, and tdata/tvalid/tlast stable during every stall.
- `entry_count`=0: expect no `rd_en` and only DE AD BE EF. `busy` falls after the EF handshake.
- Start while busy: pulse `start_dump` at byte 5 of the first word. Expect an unchanged stream and no second dump.
- Reset mid-word: drop `rst_n` during byte 3. Expect tvalid=0 and busy=0 immediately. A fresh start then produces a full, correct stream.
- With `DUMP_HEADER_EN`, `entry_count`=1: expect A5 00 01, then 8 data bytes, then the sentinel.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared state type and stream constants for dump_serializer.
// DUMP_HEADER_EN adds the HDR state used by the optional 3-byte header.
package dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
`ifdef DUMP_HEADER_EN
      ST_HDR,
`endif
      ST_RD,
      ST_WAIT,
      ST_SHIFT,
      ST_SENT
   } state_t;

   localparam logic [31:0] SENTINEL       = 32'hDEAD_BEEF;
   localparam logic [7:0]  HDR_MAGIC      = 8'hA5;
   localparam int          SENTINEL_BYTES = 4;
   localparam int          HDR_BYTES      = 3;

   // The shared shift register must also fit the 4-byte sentinel.
   function automatic int shift_width(input int word_width);
      return (word_width > SENTINEL_BYTES * 8) ? word_width : SENTINEL_BYTES * 8;
   endfunction

endpackage

// File: rtl/dump_serializer_if.sv
// Byte-wide AXI-Stream link from dump_serializer toward the UART TX stage.
// A byte transfers on a rising edge where tvalid & tready; once tvalid is high,
// tdata/tlast hold and tvalid stays high until that transfer.
interface dump_serializer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/byte_serializer.sv
// Left-justified shift register emitting load_bytes bytes MSB first on a
// registered valid/data/last stream; done pulses on the final byte's handshake.
module byte_serializer
   import dump_pkg::*;
#(
   parameter int SHIFT_W = 64,
   localparam int CNT_W  = $clog2(SHIFT_W / 8 + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [SHIFT_W-1:0] load_data,
   input  logic [CNT_W-1:0]   load_bytes,
   input  logic               load_last,
   input  logic               tready,
   output logic [7:0]         tdata,
   output logic               tvalid,
   output logic               tlast,
   output logic               done
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   logic [SHIFT_W-1:0] shift_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   nbytes_q;
   logic               last_q;
   logic               tvalid_q;
   logic               tlast_q;
   logic               hs;

   assign hs     = tvalid_q & tready;
   assign done   = hs && (cnt_q == (nbytes_q - ONE));
   assign tdata  = shift_q[SHIFT_W-1 -: 8];
   assign tvalid = tvalid_q;
   assign tlast  = tlast_q;

   // A load in the same cycle as done chains the next segment with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q  <= '0;
         cnt_q    <= '0;
         nbytes_q <= '0;
         last_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (load) begin
         shift_q  <= load_data;
         cnt_q    <= '0;
         nbytes_q <= load_bytes;
         last_q   <= load_last;
         tvalid_q <= 1'b1;
         tlast_q  <= load_last && (load_bytes == ONE);
      end else if (hs) begin
         shift_q <= shift_q << 8;
         cnt_q   <= cnt_q + ONE;
         if (done) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end else begin
            tlast_q <= last_q && ((cnt_q + TWO) == nbytes_q);
         end
      end
   end

endmodule

// File: rtl/dump_serializer.sv
// Streams entry_count log words big-endian over AXI-Stream, then DE AD BE EF.
// DUMP_HEADER_EN prepends A5 and the 16-bit word count.
module dump_serializer
   import dump_pkg::*;
#(
   parameter int WORD_WIDTH = 64,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_dump,
   input  logic [ADDR_WIDTH:0]   entry_count,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WORD_WIDTH-1:0] rd_data,
   dump_serializer_if.master     m_axis,
   output logic                  busy,
   output state_t                dbg_state
);
   localparam int SHIFT_W = shift_width(WORD_WIDTH);
   localparam int CNT_W   = $clog2(SHIFT_W / 8 + 1);

   localparam logic [CNT_W-1:0]      WORD_BYTES = CNT_W'(WORD_WIDTH / 8);
   localparam logic [CNT_W-1:0]      SENT_BYTES = CNT_W'(SENTINEL_BYTES);
   localparam logic [SHIFT_W-1:0]    SENT_WORD  = SHIFT_W'(SENTINEL) << (SHIFT_W - SENTINEL_BYTES * 8);
   localparam logic [ADDR_WIDTH:0]   MAX_COUNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   IDX_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   idx_q, idx_d;
   logic [ADDR_WIDTH:0]   clamp;

   logic                  load;
   logic [SHIFT_W-1:0]    load_data;
   logic [CNT_W-1:0]      load_bytes;
   logic                  load_last;
   logic                  done;

   assign clamp     = (entry_count > MAX_COUNT) ? MAX_COUNT : entry_count;
   assign rd_en     = (state_q == ST_RD);
   assign rd_addr   = idx_q[ADDR_WIDTH-1:0];
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      load       = 1'b0;
      load_data  = '0;
      load_bytes = '0;
      load_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_dump) begin
               count_d = clamp;
               idx_d   = '0;
`ifdef DUMP_HEADER_EN
               load       = 1'b1;
               load_data  = SHIFT_W'({HDR_MAGIC, 16'(clamp)}) << (SHIFT_W - HDR_BYTES * 8);
               load_bytes = CNT_W'(HDR_BYTES);
               state_d    = ST_HDR;
`else
               if (clamp != '0) begin
                  state_d = ST_RD;
               end else begin
                  load       = 1'b1;
                  load_data  = SENT_WORD;
                  load_bytes = SENT_BYTES;
                  load_last  = 1'b1;
                  state_d    = ST_SENT;
               end
`endif
            end
         end
`ifdef DUMP_HEADER_EN
         ST_HDR: begin
            if (done) begin
               if (count_q != '0) begin
                  state_d = ST_RD;
               end else begin
                  load       = 1'b1;
                  load_data  = SENT_WORD;
                  load_bytes = SENT_BYTES;
                  load_last  = 1'b1;
                  state_d    = ST_SENT;
               end
            end
         end
`endif
         ST_RD: state_d = ST_WAIT;
         ST_WAIT: begin
            load       = 1'b1;
            load_data  = SHIFT_W'(rd_data) << (SHIFT_W - WORD_WIDTH);
            load_bytes = WORD_BYTES;
            state_d    = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (done) begin
               idx_d = idx_q + IDX_ONE;
               // Last word: chain the sentinel straight behind the final byte.
               if ((idx_q + IDX_ONE) == count_q) begin
                  load       = 1'b1;
                  load_data  = SENT_WORD;
                  load_bytes = SENT_BYTES;
                  load_last  = 1'b1;
                  state_d    = ST_SENT;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_SENT: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   byte_serializer #(.SHIFT_W(SHIFT_W)) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_data  (load_data),
      .load_bytes (load_bytes),
      .load_last  (load_last),
      .tready     (m_axis.tready),
      .tdata      (m_axis.tdata),
      .tvalid     (m_axis.tvalid),
      .tlast      (m_axis.tlast),
      .done       (done)
   );

endmodule

// File: tb/tb_dump_serializer.sv
// Scoreboard bench for dump_serializer: directed dumps, backpressure,
// empty dump, start-while-busy, mid-stream reset and full-depth clamp.
module tb_dump_serializer;
   import dump_pkg::*;

   localparam int WW = 64;
   localparam int AW = 8;
`ifdef DUMP_HEADER_EN
   localparam int HB = 3;
`else
   localparam int HB = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start_dump = 1'b0;
   logic [AW:0]    entry_count = '0;
   logic           rd_en;
   logic [AW-1:0]  rd_addr;
   logic [WW-1:0]  rd_data = '0;
   logic           busy;
   state_t         dbg_state;
   logic           tready = 1'b1;
   int             tready_mode = 0;

   dump_serializer_if m_axis ();
   assign m_axis.tready = tready;

   dump_serializer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_dump  (start_dump),
      .entry_count (entry_count),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .m_axis      (m_axis),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // clock / reset / memory model
   always #5 clk = ~clk;

   logic [WW-1:0] mem [256];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int pat_cnt = 0;
   logic [3:0] pat = 4'b1001;
   always @(posedge clk) begin
      #1;
      tready = (tready_mode == 1) ? pat[3 - (pat_cnt % 4)] : 1'b1;
      pat_cnt++;
   end

   // scoreboard
   logic [8:0]    exp_q[$];
   logic [AW-1:0] addr_q[$];
   int checks = 0;
   int errors = 0;
   int hs_count = 0, rd_count = 0, gap_cycles = 0, busy_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: sampled on the falling edge, a handshake seen here lands on the next rising edge
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tdata}, {1'b1, prev_last, prev_data});
         if (m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {m_axis.tlast, m_axis.tdata}, 9'h1ff);
            else chk("stream_byte", {m_axis.tlast, m_axis.tdata}, exp_q.pop_front());
            hs_count++;
         end
         prev_stall = m_axis.tvalid && !m_axis.tready;
         prev_data  = m_axis.tdata;
         prev_last  = m_axis.tlast;
         if (rd_en) begin
            rd_count++;
            if (addr_q.size() == 0) chk("unexpected_read", 64'(rd_addr), 64'hffff);
            else chk("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
         end
         if (busy) busy_cycles++;
         if (busy && !m_axis.tvalid) gap_cycles++;
      end
   end

   // driver: act 0 plain, 1 start pulse during byte 5, 2 reset during byte 3
   task automatic run_dump(input int n, input int act);
      int eff;
      logic fired;
      eff = (n > 256) ? 256 : n;
`ifdef DUMP_HEADER_EN
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, 8'(eff >> 8)});
      exp_q.push_back({1'b0, 8'(eff)});
`endif
      for (int i = 0; i < eff; i++) begin
         addr_q.push_back(AW'(i));
         for (int b = 0; b < WW / 8; b++) exp_q.push_back({1'b0, mem[i][WW-1-8*b -: 8]});
      end
      exp_q.push_back({1'b0, 8'hDE});
      exp_q.push_back({1'b0, 8'hAD});
      exp_q.push_back({1'b0, 8'hBE});
      exp_q.push_back({1'b1, 8'hEF});
      hs_count = 0; rd_count = 0; gap_cycles = 0; busy_cycles = 0;
      entry_count = (AW + 1)'(n);
      start_dump = 1'b1;
      tick();
      start_dump = 1'b0;
      fired = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         if (!busy) break;
         if (act == 1 && !fired && hs_count == 4 + HB) begin
            fired = 1'b1;
            entry_count = (AW + 1)'(1);
            start_dump = 1'b1;
            tick();
            start_dump = 1'b0;
            continue;
         end
         if (act == 2 && !fired && hs_count == 2 + HB) begin
            fired = 1'b1;
            rst_n = 1'b0;
            #1;
            chk("rst_tvalid", 64'(m_axis.tvalid), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_tlast", 64'(m_axis.tlast), 0);
            chk("rst_rd_en", 64'(rd_en), 0);
            chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
            exp_q.delete();
            addr_q.delete();
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            break;
         end
         tick();
      end
      chk("dump_terminates", 64'(busy), 0);
      if (act != 0) chk("action_fired", 64'(fired), 1);
      repeat (3) tick();
      chk("stream_complete", 64'(exp_q.size()), 0);
      chk("addr_complete", 64'(addr_q.size()), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8{8'(i)}} ^ 64'h0123_4567_89AB_CDEF;
      mem[0] = 64'h0102_0304_0506_0708;
      mem[1] = 64'h1112_1314_1516_1718;

      repeat (3) tick();
      chk("reset_rd_en", 64'(rd_en), 0);
      chk("reset_rd_addr", 64'(rd_addr), 0);
      chk("reset_tdata", 64'(m_axis.tdata), 0);
      chk("reset_tvalid", 64'(m_axis.tvalid), 0);
      chk("reset_tlast", 64'(m_axis.tlast), 0);
      chk("reset_busy", 64'(busy), 0);
      rst_n = 1'b1;
      tick();

      // two words, tready held high: 2-cycle start latency plus one 2-cycle word bubble
      tready_mode = 0;
      run_dump(2, 0);
      chk("t1_bytes", 64'(hs_count), 64'(20 + HB));
      chk("t1_reads", 64'(rd_count), 2);
      chk("t1_gap_cycles", 64'(gap_cycles), 4);
      chk("t1_busy_cycles", 64'(busy_cycles), 64'(24 + HB));

      // backpressure 1,0,0,1
      tready_mode = 1;
      run_dump(2, 0);
      chk("t2_bytes", 64'(hs_count), 64'(20 + HB));
      chk("t2_reads", 64'(rd_count), 2);
      tready_mode = 0;
      repeat (2) tick();

      // empty dump: sentinel only, busy falls right after EF
      run_dump(0, 0);
      chk("t3_reads", 64'(rd_count), 0);
      chk("t3_bytes", 64'(hs_count), 64'(4 + HB));
      chk("t3_busy_cycles", 64'(busy_cycles), 64'(4 + HB));

      // start pulse while busy is dropped
      run_dump(2, 1);
      repeat (10) tick();
      chk("t4_idle_after", 64'(busy), 0);
      chk("t4_reads", 64'(rd_count), 2);
      chk("t4_bytes", 64'(hs_count), 64'(20 + HB));

      // reset mid-word, then a fresh full stream
      run_dump(2, 2);
      run_dump(2, 0);
      chk("t5_bytes", 64'(hs_count), 64'(20 + HB));
      chk("t5_reads", 64'(rd_count), 2);

      // entry_count above depth clamps to every address exactly once
      run_dump(300, 0);
      chk("t6_reads", 64'(rd_count), 256);
      chk("t6_bytes", 64'(hs_count), 64'(256 * 8 + 4 + HB));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
